uart_tx_arbiter: RTL

- Shares one uart_transmitter between N byte requesters using round-robin arbitration.
- Sequences the transmitter's write/busy handshake: drives Tx_DATA, Tx_WR, Tx_EN and baud_select, then monitors Tx_BUSY.
- Sits between on-chip byte producers and the transmitter.
- Also registers the baud configuration. A new baud value is applied only between frames.

---
 rtl/uart_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: FSM states, baud codes, 16x divisors and frame length shared by the UART transmit path
package uart_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, WRITE, WAIT_BUSY, WAIT_DONE} state_t;
  localparam logic [2:0] BAUD_300    = 3'b000;
  localparam logic [2:0] BAUD_1200   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;
  localparam int FRAME_BITS = 11;
  function automatic logic [13:0] baud_div(input logic [2:0] code);
    return code == BAUD_300    ? 14'd10417 :
           code == BAUD_1200   ? 14'd2604  :
           code == BAUD_4800   ? 14'd651   :
           code == BAUD_9600   ? 14'd326   :
           code == BAUD_19200  ? 14'd163   :
           code == BAUD_38400  ? 14'd81    :
           code == BAUD_57600  ? 14'd54    : 14'd27;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid index at or after ptr (valid/ptr in, grant/idx out)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] NW = (IW + 1)'(N);
  logic [IW:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IW + 1)'(k);
      j = j >= NW ? j - NW : j;
      idx = valid[j[IW-1:0]] ? j[IW-1:0] : idx;
    end
    grant = |valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_transmitter (req_* in, tx_* to transmitter, grant_id/active/timeout_err status)
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N            = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  input  logic [2:0]           cfg_baud_select,
  input  logic                 cfg_tx_en,
  input  logic                 err_clr,
  output logic [7:0]           tx_data,
  output logic [2:0]           tx_baud_select,
  output logic                 tx_wr,
  output logic                 tx_en,
  input  logic                 tx_busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 active,
  output logic                 timeout_err
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BUSY_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(BUSY_TIMEOUT - 1);
  state_t state, state_n;
  logic [IW-1:0] ptr, sel, ptr_next;
  logic [N-1:0] sel_oh, grant_oh;
  logic [CW-1:0] cnt;
  logic cfg_tx_en_q, start, timeout, done;
  rr_arbiter #(.N(N)) u_rr (
    .valid(req_valid),
    .ptr  (ptr),
    .grant(sel_oh),
    .idx  (sel)
  );
  assign start     = cfg_tx_en && |req_valid;
  assign timeout   = state == WAIT_BUSY && !tx_busy && cnt == CNT_MAX;
  assign done      = timeout || (state == WAIT_DONE && !tx_busy);
  assign ptr_next  = grant_id == IW'(N - 1) ? '0 : grant_id + 1'b1;
  assign req_ready = state == GRANT ? grant_oh : '0;
  assign tx_wr     = state == WRITE;
  assign active    = state != IDLE;
  assign tx_en     = cfg_tx_en_q | active;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? GRANT : IDLE;
      GRANT:     state_n = WRITE;
      WRITE:     state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = tx_busy ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY;
      WAIT_DONE: state_n = tx_busy ? WAIT_DONE : IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ptr            <= '0;
      grant_id       <= '0;
      grant_oh       <= '0;
      tx_data        <= '0;
      tx_baud_select <= '0;
      cfg_tx_en_q    <= 1'b0;
      timeout_err    <= 1'b0;
      cnt            <= '0;
    end else begin
      state       <= state_n;
      cfg_tx_en_q <= cfg_tx_en;
      cnt         <= state == WAIT_BUSY ? cnt + 1'b1 : '0;
      // a set wins over a simultaneous clear
      timeout_err <= timeout | (timeout_err & ~err_clr);
      if (state == IDLE) tx_baud_select <= cfg_baud_select;
      if (state == IDLE && start) begin
        grant_id <= sel;
        grant_oh <= sel_oh;
      end
      if (state == GRANT) tx_data <= req_data[{grant_id, 3'b000} +: 8];
      if (done) ptr <= ptr_next;
    end
  end
endmodule
